sqrt_seq: RTL

- Iterative, parametrised unsigned fixed-point square root.
- Input is an unsigned integer A (U(IN_W,0)). Output is Y = floor(sqrt(A)·2^FRAC_W), returned as U(INT_W,FRAC_W).
- Computes one result bit per clock using the restoring digit-by-digit algorithm.
- Replaces table-based combinational square roots in datapaths that need wider operands, with valid/ready handshakes on both sides.

---
 rtl/sqrt_seq_if.sv | 24 ++
 rtl/sqrt_seq.sv | 97 +++++++++
 2 files changed

// File: rtl/sqrt_seq_if.sv
// rtl/sqrt_seq_if.sv - operand/result handshake bundle for sqrt_seq
interface sqrt_seq_if #(
    parameter int IN_W   = 8,
    parameter int FRAC_W = 4
);
    localparam int OUT_W = (IN_W + 1) / 2 + FRAC_W;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sqrt_seq.sv
// rtl/sqrt_seq.sv - iterative restoring fixed-point square root, one result bit per clock
// Optional round-to-nearest step enabled by defining SQRT_ROUND_EN.
module sqrt_seq #(
    parameter int IN_W   = 8,
    parameter int FRAC_W = 4
) (
    input  logic clk,
    input  logic rst,
    sqrt_seq_if.slave bus
);
    localparam int INT_W = (IN_W + 1) / 2;
    localparam int OUT_W = INT_W + FRAC_W;
    localparam int RAD_W = 2 * OUT_W;
    localparam int REM_W = OUT_W + 2;
    localparam int CNT_W = $clog2(OUT_W + 1);

`ifdef SQRT_ROUND_EN
    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE, ST_ROUND} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;
`endif

    state_t             r_state;
    state_t             w_next;
    logic [RAD_W-1:0]   r_rad;
    logic [OUT_W-1:0]   r_q;
    logic [REM_W-1:0]   r_rem;
    logic [CNT_W-1:0]   r_cnt;
    logic [REM_W-1:0]   w_rem_sh;
    logic [REM_W:0]     w_trial;

    // Remainder never exceeds 2*Q, so REM_W bits hold the shifted value without loss.
    assign w_rem_sh = (r_rem << 2) | REM_W'(r_rad[RAD_W-1 -: 2]);
    assign w_trial  = {1'b0, w_rem_sh} - {1'b0, r_q, 2'b01};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid) w_next = ST_CALC;
`ifdef SQRT_ROUND_EN
            ST_CALC:  if (r_cnt == '0) w_next = ST_ROUND;
            ST_ROUND: w_next = ST_DONE;
`else
            ST_CALC:  if (r_cnt == '0) w_next = ST_DONE;
`endif
            ST_DONE: if (bus.out_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rad <= '0;
            r_q   <= '0;
            r_rem <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_rad <= RAD_W'(bus.in_data) << (2 * FRAC_W);
                        r_q   <= '0;
                        r_rem <= '0;
                        r_cnt <= CNT_W'(OUT_W - 1);
                    end
                end
                ST_CALC: begin
                    r_rad <= r_rad << 2;
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                    if (!w_trial[REM_W]) begin
                        r_rem <= w_trial[REM_W-1:0];
                        r_q   <= (r_q << 1) | OUT_W'(1);
                    end else begin
                        r_rem <= w_rem_sh;
                        r_q   <= r_q << 1;
                    end
                end
`ifdef SQRT_ROUND_EN
                ST_ROUND: begin
                    // rem > Q means A*4^FRAC_W exceeds Q^2+Q, i.e. the true root is past Q+0.5.
                    if ((r_rem > REM_W'(r_q)) && (r_q != '1)) r_q <= r_q + 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.out_data  = r_q;
endmodule
